// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops one word from the TX FIFO and sends it as
// start bit, DATA_W data bits LSB first, optional parity bit, and 1 or 2 stop bits.
module uart_tx_engine #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_req,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;

    localparam int               BIT_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);

    logic [2:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_n;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_en_q;
    logic              stop2_q;
    logic              parity_bit;
    logic              bit_end;

    assign bit_end = (div_cnt == div_n - DIV_W'(1));

    // NOTE: the pop request is decoded combinationally so the very first IDLE
    // cycle can pop; it is gated by rst so a held reset can never drain the FIFO.
    assign fifo_rd_req = (state == IDLE) && !fifo_empty && !rst;

    // tx is a pure decode of registered state, so an async reset forces it high at once.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift_reg[0];
            PARITY:  tx = parity_bit;
            default: tx = 1'b1;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            div_n      <= DIV_W'(1);
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            parity_bit <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (state inside {START, DATA, PARITY, STOP})
                div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    // Frame configuration is frozen here until the next pop.
                    shift_reg  <= fifo_rd_data;
                    div_n      <= (baud_div == '0) ? DIV_W'(1) : baud_div;
                    par_en_q   <= parity_en;
                    stop2_q    <= stop2;
                    parity_bit <= (^fifo_rd_data) ^ parity_odd;
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    state      <= START;
                end
                START: begin
                    if (bit_end)
                        state <= DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end)
                        state <= STOP;
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_W'(stop2_q)) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a FIFO model feeds words, a line
// monitor decodes tx cycle by cycle against a scoreboard of expected frames.
module tb_uart_tx_engine;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        par_en;
        logic        par_odd;
        logic        stop2;
        int          exp_cycles;
        logic        exp_par;
        logic        b2b;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_req;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        tx;
    logic        busy;
    logic        tx_done;

    uart_tx_engine #(.DATA_W(8), .DIV_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_req  (fifo_rd_req),
        .baud_div     (baud_div),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .stop2        (stop2),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int pops = 0;
    int bad_pops = 0;
    int done_cnt = 0;
    int frames_done = 0;
    int aborts = 0;
    logic pop_seen = 1'b0;
    logic mon_active = 1'b0;

    logic [7:0] fifo_q[$];
    frame_t     sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO model: data appears the cycle after a pop, like a registered FIFO read port.
    always @(negedge clk) begin
        pop_seen = fifo_rd_req;
        if (fifo_rd_req) begin
            pops++;
            if (fifo_empty || busy) bad_pops++;
        end
        if (tx_done) done_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (pop_seen && fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    end

    // Line monitor
    frame_t mon_e;
    logic   mon_seq[12];
    int     mon_n, mon_nb, mon_len, mon_errs, mon_start;
    int     mon_last_done = 0;
    logic   mon_par;
    bit     mon_abort;

    always begin
        @(negedge clk);
        if (!rst && tx === 1'b0) begin
            mon_active = 1'b1;
            mon_start  = cyc;
            check("sb_has_entry", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) mon_e = sb_q.pop_front();
            else mon_e = '{data:8'h00, div:16'd1, par_en:1'b0, par_odd:1'b0, stop2:1'b0,
                           exp_cycles:0, exp_par:1'b0, b2b:1'b0};
            mon_n  = (mon_e.div == 16'd0) ? 1 : int'(mon_e.div);
            mon_nb = 0;
            mon_seq[mon_nb++] = 1'b0;
            for (int i = 0; i < 8; i++) mon_seq[mon_nb++] = mon_e.data[i];
            if (mon_e.par_en) mon_seq[mon_nb++] = (^mon_e.data) ^ mon_e.par_odd;
            mon_seq[mon_nb++] = 1'b1;
            if (mon_e.stop2) mon_seq[mon_nb++] = 1'b1;

            mon_len = 0; mon_errs = 0; mon_abort = 1'b0; mon_par = 1'b0;
            while (tx_done !== 1'b1 && mon_len < 5000) begin
                if (rst) begin
                    mon_abort = 1'b1;
                    break;
                end
                if (mon_len < mon_nb * mon_n) begin
                    if (tx !== mon_seq[mon_len / mon_n] || busy !== 1'b1) mon_errs++;
                    if (mon_e.par_en && mon_len == 9 * mon_n) mon_par = tx;
                end
                mon_len++;
                @(negedge clk);
            end

            if (mon_abort) begin
                aborts++;
                mon_active = 1'b0;
                while (rst) @(negedge clk);
            end else begin
                check("frame_len", mon_len, mon_e.exp_cycles);
                check("frame_bits", mon_errs, 0);
                if (mon_e.par_en) check("parity_bit", mon_par, mon_e.exp_par);
                check("done_busy_low", busy, 0);
                if (mon_e.b2b) check("interframe_gap", mon_start - mon_last_done, 2);
                mon_last_done = cyc;
                mon_active = 1'b0;
                frames_done++;
                @(negedge clk);
                check("done_one_cycle", tx_done, 0);
            end
        end
    end

    task automatic send(input frame_t f);
        baud_div   = f.div;
        parity_en  = f.par_en;
        parity_odd = f.par_odd;
        stop2      = f.stop2;
        sb_q.push_back(f);
        fifo_q.push_back(f.data);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_timeout", frames_done >= target, 1);
    endtask

    task automatic wait_active(input int budget);
        int k = 0;
        while (!mon_active && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("start_timeout", mon_active, 1);
    endtask

    frame_t vecs[7];
    frame_t f;

    initial begin
        int idle_bad;
        int base_frames, base_pops, base_done;

        vecs[0] = '{data:8'h55, div:16'd4, par_en:1'b0, par_odd:1'b0, stop2:1'b0, exp_cycles:40, exp_par:1'b0, b2b:1'b0};
        vecs[1] = '{data:8'h07, div:16'd3, par_en:1'b1, par_odd:1'b0, stop2:1'b0, exp_cycles:33, exp_par:1'b1, b2b:1'b0};
        vecs[2] = '{data:8'h07, div:16'd3, par_en:1'b1, par_odd:1'b1, stop2:1'b0, exp_cycles:33, exp_par:1'b0, b2b:1'b0};
        vecs[3] = '{data:8'h3C, div:16'd1, par_en:1'b1, par_odd:1'b1, stop2:1'b1, exp_cycles:12, exp_par:1'b1, b2b:1'b0};
        vecs[4] = '{data:8'h00, div:16'd2, par_en:1'b1, par_odd:1'b0, stop2:1'b0, exp_cycles:22, exp_par:1'b0, b2b:1'b0};
        vecs[5] = '{data:8'hFF, div:16'd5, par_en:1'b1, par_odd:1'b1, stop2:1'b0, exp_cycles:55, exp_par:1'b1, b2b:1'b0};
        vecs[6] = '{data:8'h01, div:16'd7, par_en:1'b0, par_odd:1'b0, stop2:1'b1, exp_cycles:77, exp_par:1'b0, b2b:1'b0};

        rst = 1'b1; baud_div = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", tx_done, 0);
        check("reset_rd_req", fifo_rd_req, 0);

        // Idle with an empty FIFO
        rst = 1'b0;
        idle_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        check("idle_hold", idle_bad, 0);
        check("idle_no_pop", pops, 0);

        // Table-driven single frames
        for (int i = 0; i < 7; i++) begin
            send(vecs[i]);
            wait_frames(i + 1, 2000);
        end
        check("table_pops", pops, 7);

        // Divisor 0, two stop bits, two words queued back to back
        base_frames = frames_done; base_pops = pops;
        f = '{data:8'hA5, div:16'd0, par_en:1'b0, par_odd:1'b0, stop2:1'b1, exp_cycles:11, exp_par:1'b0, b2b:1'b0};
        send(f);
        f = '{data:8'h3C, div:16'd0, par_en:1'b0, par_odd:1'b0, stop2:1'b1, exp_cycles:11, exp_par:1'b0, b2b:1'b1};
        send(f);
        wait_frames(base_frames + 2, 500);
        check("b2b_pops", pops - base_pops, 2);

        // Divisor and parity changed mid-frame only affect the next frame
        base_frames = frames_done;
        f = '{data:8'h96, div:16'd4, par_en:1'b0, par_odd:1'b0, stop2:1'b0, exp_cycles:40, exp_par:1'b0, b2b:1'b0};
        send(f);
        wait_active(200);
        repeat (20) @(negedge clk);
        f = '{data:8'h5A, div:16'd10, par_en:1'b1, par_odd:1'b0, stop2:1'b0, exp_cycles:110, exp_par:1'b0, b2b:1'b1};
        send(f);
        wait_frames(base_frames + 2, 1000);

        // Reset during data bit 3 aborts the frame
        base_pops = pops; base_done = done_cnt;
        f = '{data:8'hFF, div:16'd8, par_en:1'b0, par_odd:1'b0, stop2:1'b0, exp_cycles:80, exp_par:1'b0, b2b:1'b0};
        send(f);
        wait_active(200);
        repeat (34) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", tx_done, 0);
        check("abort_rd_req", fifo_rd_req, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        check("post_abort_idle", idle_bad, 0);
        check("post_abort_no_done", done_cnt - base_done, 0);
        check("post_abort_pops", pops - base_pops, 1);
        check("abort_seen", aborts, 1);

        check("pop_when_empty_or_busy", bad_pops, 0);
        check("scoreboard_drained", sb_q.size(), 0);
        check("total_frames", frames_done, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
